switch_bank: RTL and testbench

Multi-channel debouncer and edge/auto-repeat generator for mechanical push switches. It replaces per-switch single-channel debouncers with one shared sampling prescaler feeding CHANNELS independent debounce engines. Each engine requires STABLE_SAMPLES consecutive agreeing samples before its level changes, and adds an optional hold-to-repeat pulse. It sits between the board switch pins and the control logic that consumes one-cycle `pos`/`neg` events.

---
 rtl/switch_bank.sv | 137 +++++++++++++
 tb/tb_switch_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switch_bank.sv
// switch_bank: multi-channel push-switch debouncer with edge and auto-repeat
// pulse generation. A single free-running prescaler produces a sample tick
// shared by all channels; each channel has its own two-flop synchronizer,
// stable-sample counter and hold-to-repeat counter.
//
// Ports:
//   CLK  in                system clock, rising edge
//   RST  in                synchronous active-high reset
//   sw   in  [CHANNELS]    raw switch inputs (1 = pressed), asynchronous
//   d    out [CHANNELS]    debounced level
//   pos  out [CHANNELS]    one-cycle pulse on accepted press
//   neg  out [CHANNELS]    one-cycle pulse on accepted release
//   rep  out [CHANNELS]    one-cycle auto-repeat pulse while held
module switch_bank #(
  parameter int CHANNELS       = 4,
  parameter int COUNTER_BITS   = 17,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] sw,
  output logic [CHANNELS-1:0] d,
  output logic [CHANNELS-1:0] pos,
  output logic [CHANNELS-1:0] neg,
  output logic [CHANNELS-1:0] rep
);

  localparam int CW   = $clog2(STABLE_SAMPLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  // Accepting when the current count is one short of the target avoids an
  // extra adder width in the compare.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE   = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_ONE    = RW'(1);

  logic [COUNTER_BITS-1:0] prescaler_q;
  logic [CHANNELS-1:0]     s1_q, s2_q;
  logic [CHANNELS-1:0]     d_q, d_d;
  logic [CHANNELS-1:0]     pos_q, pos_d;
  logic [CHANNELS-1:0]     neg_q, neg_d;
  logic [CHANNELS-1:0]     rep_q, rep_d;
  logic [CW-1:0]           cnt_q  [CHANNELS];
  logic [CW-1:0]           cnt_d  [CHANNELS];
  logic [RW-1:0]           rcnt_q [CHANNELS];
  logic [RW-1:0]           rcnt_d [CHANNELS];
  logic                    tick;

  // Decoded from the register so the cycle right after reset is a tick.
  assign tick = (prescaler_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      d_q         <= '0;
      pos_q       <= '0;
      neg_q       <= '0;
      rep_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
      s1_q        <= sw;
      s2_q        <= s1_q;
      d_q         <= d_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      rep_q       <= rep_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  always_comb begin
    d_d   = d_q;
    pos_d = '0;
    neg_d = '0;
    rep_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      rcnt_d[i] = rcnt_q[i];
    end

    if (tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Debounce: any agreeing sample restarts accumulation.
        if (s2_q[i] != d_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            d_d[i]   = s2_q[i];
            cnt_d[i] = '0;
            pos_d[i] = s2_q[i];
            neg_d[i] = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end

        // Repeat: pos_d/neg_d here mean "press/release accepted this tick".
        if (REPEAT_EN != 0) begin
          if (pos_d[i]) begin
            rcnt_d[i] = R_DELAY;
          end else if (neg_d[i]) begin
            rcnt_d[i] = '0;
          end else if (d_q[i]) begin
            if (rcnt_q[i] == R_ONE) begin
              rep_d[i]  = 1'b1;
              rcnt_d[i] = R_RATE;
            end else if (rcnt_q[i] != '0) begin
              rcnt_d[i] = rcnt_q[i] - 1'b1;
            end
          end else begin
            rcnt_d[i] = '0;
          end
        end
      end
    end
  end

  assign d   = d_q;
  assign pos = pos_q;
  assign neg = neg_q;
  assign rep = rep_q;

endmodule

// File: tb/tb_switch_bank.sv
// Testbench for switch_bank. Two instances share the stimulus: one with the
// repeat generator enabled, one with it disabled. Expected output events
// (cycle number plus pos/neg/rep/d) are queued as stimulus is issued; the
// monitor pops one whenever the enabled instance shows a pulse.
module tb_switch_bank;

  typedef struct {
    int         cyc;
    logic [1:0] pos;
    logic [1:0] neg;
    logic [1:0] rep;
    logic [1:0] d;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [1:0] sw;
  logic [1:0] d_a, pos_a, neg_a, rep_a;
  logic [1:0] d_b, pos_b, neg_b, rep_b;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;
  exp_t exp_q[$];

  localparam int END_CYC = 205;

  switch_bank #(
    .CHANNELS(2), .COUNTER_BITS(2), .STABLE_SAMPLES(3),
    .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut_a (
    .CLK(CLK), .RST(RST), .sw(sw),
    .d(d_a), .pos(pos_a), .neg(neg_a), .rep(rep_a)
  );

  switch_bank #(
    .CHANNELS(2), .COUNTER_BITS(2), .STABLE_SAMPLES(3),
    .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut_b (
    .CLK(CLK), .RST(RST), .sw(sw),
    .d(d_b), .pos(pos_b), .neg(neg_b), .rep(rep_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] n,
                      input logic [1:0] r, input logic [1:0] dd);
    exp_t e;
    e.cyc = c; e.pos = p; e.neg = n; e.rep = r; e.d = dd;
    exp_q.push_back(e);
  endtask

  task automatic after_edge(input int n);
    wait (cyc >= n);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (cyc >= 1 && cyc <= 3) begin
      chk("reset_outs_a", {pos_a, neg_a, rep_a, d_a}, 8'h00);
      chk("reset_outs_b", {pos_b, neg_b, rep_b, d_b}, 8'h00);
    end
    if (cyc == 3)
      chk("prescaler_after_reset", {6'd0, dut_a.prescaler_q}, 8'h00);
    if (cyc == 172) begin
      chk("midreset_outs_a", {pos_a, neg_a, rep_a, d_a}, 8'h00);
      chk("midreset_outs_b", {pos_b, neg_b, rep_b, d_b}, 8'h00);
    end

    if (cyc > 3) begin
      if ((pos_a | neg_a | rep_a) != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d pos=%b neg=%b rep=%b d=%b",
                   cyc, pos_a, neg_a, rep_a, d_a);
        end else begin
          e = exp_q.pop_front();
          chk_int("event_cycle", cyc, e.cyc);
          chk("event_outs_a", {pos_a, neg_a, rep_a, d_a}, {e.pos, e.neg, e.rep, e.d});
          chk("event_outs_b_norep", {pos_b, neg_b, rep_b, d_b}, {e.pos, e.neg, 2'b00, e.d});
        end
      end else if ((pos_b | neg_b | rep_b) != 2'b00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event_b cyc=%0d pos=%b neg=%b rep=%b",
                 cyc, pos_b, neg_b, rep_b);
      end

      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_event actual=none required=cyc%0d pos=%b neg=%b rep=%b",
                 e.cyc, e.pos, e.neg, e.rep);
      end
    end

    if (cyc == END_CYC) begin
      chk_int("queue_drained", exp_q.size(), 0);
      done = 1;
    end
  end

  // Stimulus. Tick edges are multiples of 4 until the mid-run reset at edge
  // 172, after which they fall on 173, 177, ...  A change driven just after
  // edge E is first seen by the debouncer at the first tick at or after E+3.
  initial begin
    RST = 1'b1;
    sw  = 2'b11;
    after_edge(3);
    RST = 1'b0;
    sw  = 2'b00;

    // Clean press on ch0, auto-repeat, release on the tick a rep would be due.
    after_edge(8);
    sw = 2'b01;
    push(20, 2'b01, 2'b00, 2'b00, 2'b01);
    push(36, 2'b00, 2'b00, 2'b01, 2'b01);
    push(44, 2'b00, 2'b00, 2'b01, 2'b01);
    push(52, 2'b00, 2'b00, 2'b01, 2'b01);
    push(60, 2'b00, 2'b00, 2'b01, 2'b01);
    push(68, 2'b00, 2'b00, 2'b01, 2'b01);
    push(76, 2'b00, 2'b01, 2'b00, 2'b00);
    after_edge(64);
    sw = 2'b00;

    // Bounce: 2 ticks high, 1 tick low, five times; never accepted.
    for (int k = 0; k < 5; k++) begin
      after_edge(80 + 12 * k);
      sw = 2'b01;
      after_edge(88 + 12 * k);
      sw = 2'b00;
    end

    // Press ch1, then swap so ch0 press and ch1 release land together.
    after_edge(140);
    sw = 2'b10;
    push(152, 2'b10, 2'b00, 2'b00, 2'b10);
    after_edge(152);
    sw = 2'b01;
    push(164, 2'b01, 2'b10, 2'b00, 2'b01);

    // One-cycle reset while ch0 held with a repeat pending.
    after_edge(171);
    RST = 1'b1;
    after_edge(172);
    RST = 1'b0;
    push(185, 2'b01, 2'b00, 2'b00, 2'b01);
    push(201, 2'b00, 2'b00, 2'b01, 2'b01);

    wait (done);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=run_complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
